// File: rtl/prf_free_list.sv
// Physical register free list for the rename stage.
// A circular buffer of free physical tags with three pointers: head (next
// speculative allocation), chead (oldest uncommitted allocation) and tail
// (next write slot for tags returned at retirement). A flush rewinds head to
// chead, returning every uncommitted allocation to the allocatable pool.
module prf_free_list #(
   parameter  int NUM_PREGS = 256,
   parameter  int NUM_AREGS = 32,
   localparam int TAG_W     = $clog2(NUM_PREGS),
   localparam int CNT_W     = $clog2(NUM_PREGS + 1)
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             AllocReq,
   output logic             AllocReady,
   output logic [TAG_W-1:0] AllocTag,
   input  logic             FreeValid,
   input  logic [TAG_W-1:0] FreeTag,
   input  logic             CommitValid,
   input  logic             Flush,
   output logic [CNT_W-1:0] FreeCount,
   output logic             Error
);

   localparam int D     = NUM_PREGS - NUM_AREGS;
   localparam int PTR_W = $clog2(D);

   logic [TAG_W-1:0] mem [D];
   logic [PTR_W-1:0] head, chead, tail;
   logic [CNT_W-1:0] total;      // entries from chead to tail
   logic [CNT_W-1:0] free_cnt;   // entries from head to tail
   logic             err;

   logic             alloc_fire;
   logic             free_ok, free_bad;
   logic             commit_ok, commit_bad;
   logic [PTR_W-1:0] chead_nxt;
   logic [CNT_W-1:0] total_nxt;

   // Pointer increment with wrap at D-1, since D need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(D - 1)) ? '0 : p + 1'b1;
   endfunction

   // Show-ahead outputs: the next tag to grant is always visible at head.
   assign AllocTag   = mem[head];
   assign AllocReady = (free_cnt != '0);
   assign FreeCount  = free_cnt;
   assign Error      = err;

   // Decode this cycle's operations and the committed-side next state.
   always_comb begin
      alloc_fire = AllocReq && AllocReady && !Flush;
      free_ok    = FreeValid && (total != CNT_W'(D));
      free_bad   = FreeValid && (total == CNT_W'(D));
      // Uncommitted allocations are exactly total - free_cnt; comparing the
      // counts rather than chead/head also covers a fully wrapped buffer.
      commit_ok  = CommitValid && (total != free_cnt);
      commit_bad = CommitValid && (total == free_cnt);
      chead_nxt  = commit_ok ? ptr_inc(chead) : chead;
      total_nxt  = total + CNT_W'(free_ok) - CNT_W'(commit_ok);
   end

   // Pointer and counter registers; a flush rewinds head to the post-commit chead.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         head     <= '0;
         chead    <= '0;
         tail     <= '0;
         total    <= CNT_W'(D);
         free_cnt <= CNT_W'(D);
      end else begin
         chead <= chead_nxt;
         total <= total_nxt;
         if (free_ok)
            tail <= ptr_inc(tail);
         if (Flush) begin
            head     <= chead_nxt;
            free_cnt <= total_nxt;
         end else begin
            if (alloc_fire)
               head <= ptr_inc(head);
            free_cnt <= free_cnt + CNT_W'(free_ok) - CNT_W'(alloc_fire);
         end
      end
   end

   // Tag storage; returned tags are written at tail and never bypassed to head.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         // NOTE: this memory is deliberately reset, because its initial
         // contents are the initial free tags NUM_AREGS..NUM_PREGS-1; it must
         // therefore stay in flops rather than map to a RAM macro.
         for (int i = 0; i < D; i++)
            mem[i] <= TAG_W'(NUM_AREGS + i);
      end else if (free_ok) begin
         mem[tail] <= FreeTag;
      end
   end

   // Sticky protocol-violation flag: free into a full list or commit with nothing uncommitted.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n)
         err <= 1'b0;
      else if (free_bad || commit_bad)
         err <= 1'b1;
   end

endmodule

// File: tb/tb_prf_free_list.sv
// Self-checking bench for prf_free_list: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based model of the free list.
module tb_prf_free_list;

   localparam int NP = 256;
   localparam int NA = 32;
   localparam int D  = NP - NA;

   logic       CLK = 1'b0;
   logic       Reset_n = 1'b0;
   logic       AllocReq = 1'b0;
   logic       AllocReady;
   logic [7:0] AllocTag;
   logic       FreeValid = 1'b0;
   logic [7:0] FreeTag = '0;
   logic       CommitValid = 1'b0;
   logic       Flush = 1'b0;
   logic [8:0] FreeCount;
   logic       Error;

   int vectors     = 0;
   int miscompares = 0;

   prf_free_list #(.NUM_PREGS(NP), .NUM_AREGS(NA)) dut (
      .CLK         (CLK),
      .Reset_n     (Reset_n),
      .AllocReq    (AllocReq),
      .AllocReady  (AllocReady),
      .AllocTag    (AllocTag),
      .FreeValid   (FreeValid),
      .FreeTag     (FreeTag),
      .CommitValid (CommitValid),
      .Flush       (Flush),
      .FreeCount   (FreeCount),
      .Error       (Error)
   );

   always #5 CLK = ~CLK;

   // Model: avail_q holds allocatable tags in grant order, spec_q holds
   // granted-but-uncommitted tags oldest first.
   logic [7:0] avail_q[$];
   logic [7:0] spec_q[$];
   logic       m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model update, one step per clock edge; reset is asynchronous like the DUT.
   always @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         avail_q.delete();
         spec_q.delete();
         for (int i = 0; i < D; i++) avail_q.push_back(8'(NA + i));
         m_err = 1'b0;
      end else begin
         int  tot0;
         bit  fire;
         logic [7:0] t;
         tot0 = avail_q.size() + spec_q.size();
         fire = AllocReq && (avail_q.size() != 0) && !Flush;
         if (CommitValid) begin
            if (spec_q.size() == 0) m_err = 1'b1;
            else t = spec_q.pop_front();
         end
         if (fire) begin
            t = avail_q.pop_front();
            spec_q.push_back(t);
         end
         if (FreeValid) begin
            if (tot0 == D) m_err = 1'b1;
            else avail_q.push_back(FreeTag);
         end
         if (Flush) begin
            avail_q = {spec_q, avail_q};
            spec_q.delete();
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      if (Reset_n) begin
         check("alloc_ready", 32'(AllocReady), 32'(avail_q.size() != 0));
         check("free_count",  32'(FreeCount),  32'(avail_q.size()));
         check("error",       32'(Error),      32'(m_err));
         if (avail_q.size() != 0)
            check("alloc_tag", 32'(AllocTag), 32'(avail_q[0]));
      end
   end

   task automatic drive(input logic req, input logic fv, input logic [7:0] ft,
                        input logic cv, input logic fl);
      AllocReq    = req;
      FreeValid   = fv;
      FreeTag     = ft;
      CommitValid = cv;
      Flush       = fl;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      Reset_n = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1 Reset_n = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // Reset values.
      do_reset();
      check("rst_ready", 32'(AllocReady), 32'd1);
      check("rst_tag",   32'(AllocTag),   32'd32);
      check("rst_count", 32'(FreeCount),  32'd224);
      check("rst_error", 32'(Error),      32'd0);

      // Three back-to-back grants in order.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
         check("grant_seq", 32'(AllocTag), 32'(32 + k));
         tick();
      end
      check("count_221", 32'(FreeCount), 32'd221);

      // Ten allocs, four commits, flush: uncommitted six return to the pool.
      do_reset();
      repeat (10) begin drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0); tick(); end
      repeat (4)  begin drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0); tick(); end
      drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
      tick();
      check("flush_count", 32'(FreeCount), 32'd220);
      check("flush_tag",   32'(AllocTag),  32'd36);
      check("flush_error", 32'(Error),     32'd0);

      // Exhaust the list (committing along the way so a free is legal), then
      // a freed tag must not be granted in the cycle it is returned.
      do_reset();
      drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      tick();
      repeat (D - 1) begin drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0); tick(); end
      check("empty_ready", 32'(AllocReady), 32'd0);
      check("empty_count", 32'(FreeCount),  32'd0);
      drive(1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
      check("no_bypass", 32'(AllocReady), 32'd0);
      tick();
      check("freed_ready", 32'(AllocReady), 32'd1);
      check("freed_tag",   32'(AllocTag),   32'd5);

      // Stream 230 frees through the buffer alongside allocs and commits so
      // every pointer crosses the D-1 -> 0 boundary; order is checked each cycle.
      for (int k = 0; k < 230; k++) begin
         drive(1'b1, 1'b1, 8'(k * 7 + 3), 1'(spec_q.size() != 0), 1'b0);
         tick();
      end
      check("wrap_error", 32'(Error), 32'd0);

      // Protocol violations: commit with nothing outstanding, free into a full list.
      do_reset();
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      tick();
      check("bad_commit_err", 32'(Error), 32'd1);
      drive(1'b0, 1'b1, 8'd9, 1'b0, 1'b0);
      tick();
      check("full_free_count", 32'(FreeCount), 32'd224);
      check("full_free_tag",   32'(AllocTag),  32'd32);
      repeat (3) tick();
      check("err_sticky", 32'(Error), 32'd1);

      // Asynchronous reset between edges after 50 allocations.
      do_reset();
      repeat (50) begin drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0); tick(); end
      check("pre_async_count", 32'(FreeCount), 32'd174);
      #2 Reset_n = 1'b0;
      #1;
      check("async_ready", 32'(AllocReady), 32'd1);
      check("async_tag",   32'(AllocTag),   32'd32);
      check("async_count", 32'(FreeCount),  32'd224);
      check("async_error", 32'(Error),      32'd0);
      @(negedge CLK);
      #1 Reset_n = 1'b1;
      @(posedge CLK);
      #1;

      // Randomized traffic, mostly legal with occasional violations and flushes.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         logic req, fv, cv, fl;
         int   tot;
         tot = avail_q.size() + spec_q.size();
         req = ($urandom_range(99) < 60);
         fv  = ($urandom_range(99) < 45) && ((tot < D) || ($urandom_range(99) < 3));
         cv  = ($urandom_range(99) < 50) && ((spec_q.size() != 0) || ($urandom_range(99) < 2));
         fl  = ($urandom_range(99) < 4);
         drive(req, fv, 8'($urandom), cv, fl);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prf_free_list.md
PRF_FREE_LIST -- requirements
Module: prf_free_list

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 256, meaning the physical register count (tag width 8 bits).
REQ-002 SHALL have parameter NUM_AREGS, default 32, meaning the architectural register count; list depth D = NUM_PREGS-NUM_AREGS (224).
REQ-003 SHALL use one clock CLK; reset Reset_n is asynchronous and active-low.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  asynchronous active-low reset.
REQ-006 AllocReq  input  1  rename stage requests one physical tag this cycle.
REQ-007 AllocReady  output  1  a free tag is available.
REQ-008 AllocTag  output  8  tag granted when AllocReq && AllocReady.
REQ-009 FreeValid  input  1  retired instruction returns one tag.
REQ-010 FreeTag  input  8  tag being returned.
REQ-011 CommitValid  input  1  oldest speculative allocation becomes non-speculative.
REQ-012 Flush  input  1  mispredict recovery; discard all uncommitted allocations.
REQ-013 FreeCount  output  9  number of tags currently allocatable.
REQ-014 Error  output  1  sticky protocol-violation flag.

Function
REQ-015 SHALL store tags in a D-entry circular buffer with pointers Head (speculative alloc), CHead (committed alloc) and Tail (write); all pointers SHALL wrap from D-1 to 0 (non-power-of-two wrap).
REQ-016 SHALL drive AllocTag = mem[Head] combinationally (show-ahead) and AllocReady = (FreeCount != 0).
REQ-017 Alloc fires when AllocReq && AllocReady && !Flush; Head advances by 1 and FreeCount decrements next edge.
REQ-018 FreeValid SHALL write FreeTag to mem[Tail] and advance Tail; FreeCount increments next edge.
REQ-019 Simultaneous alloc and free SHALL leave FreeCount unchanged; a tag freed in cycle N SHALL NOT be grantable before cycle N+1 (no bypass, even when FreeCount is 0).
REQ-020 SHALL track Total = entries from CHead to Tail; FreeValid with Total == D SHALL be dropped and set Error.
REQ-021 CommitValid SHALL advance CHead by 1; CommitValid with CHead == Head (nothing uncommitted) SHALL be ignored and set Error.
REQ-022 Flush SHALL set Head to CHead (after any same-cycle CommitValid, i.e. CHead+1) and FreeCount to Total (after any same-cycle free), effective next edge.
REQ-023 Alloc SHALL be suppressed in a Flush cycle; FreeValid and CommitValid in the same cycle SHALL still be honored.
REQ-024 Error SHALL remain 1 until reset.

Reset
REQ-025 On Reset_n low, mem[i] SHALL be NUM_AREGS+i for i in 0..D-1 (P0..P31 are initial architectural mappings).
REQ-026 On Reset_n low, Head = CHead = Tail = 0 and Total = D.
REQ-027 Output reset values SHALL be AllocReady = 1, AllocTag = 32, FreeCount = 224, Error = 0.
REQ-028 Reset asserted mid-operation SHALL immediately discard all pointers and stored tags, restoring REQ-025..027 without waiting for CLK.

Verification
REQ-029 Release reset, AllocReq=1 for 3 cycles -> AllocTag 32, 33, 34 granted; FreeCount 224 -> 221.
REQ-030 Allocate all 224 tags -> AllocReady=0, FreeCount=0 after the 224th grant; FreeValid FreeTag=5 with AllocReq=1 in that cycle -> no grant that cycle; next cycle AllocTag=5 granted.
REQ-031 Allocate 10 tags, CommitValid 4 times, Flush -> next cycle FreeCount=220, AllocTag=36; Error=0.
REQ-032 Drain and refill across the D-1 to 0 boundary (fill 224, then free 230 tags interleaved with allocs) -> tags emerge in FIFO order across the wrap, with no corruption.
REQ-033 CommitValid with no outstanding allocation -> Error=1 sticky; FreeValid when Total=224 -> tag dropped, FreeCount stays 224.
REQ-034 Assert Reset_n low between clock edges after 50 allocs -> outputs immediately AllocReady=1, AllocTag=32, FreeCount=224, Error=0.
